// File: rtl/fsk_pkg.sv
// Shared types and constants for the FSK key framer: FSM states, frame
// geometry and the width of the baud counter.
package fsk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } fsk_state_t;

    localparam int   FSK_DATA_BITS  = 8;
    localparam logic FSK_IDLE_LEVEL = 1'b1;
    localparam int   FSK_CNT_W      = 24;

endpackage

// File: rtl/fsk_baud_gen.sv
// Baud counter for the key framer. Counts 0..BAUD_DIV-1 and wraps; restart
// forces the count back to zero so a new frame begins on a clean bit boundary.
module fsk_baud_gen
    import fsk_pkg::*;
#(
    parameter int BAUD_DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end,
    output logic bit_start
);

    localparam logic [FSK_CNT_W-1:0] LAST     = FSK_CNT_W'(BAUD_DIV - 1);
    localparam logic [FSK_CNT_W-1:0] PRE_LAST = FSK_CNT_W'(BAUD_DIV - 2);

    logic [FSK_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + FSK_CNT_W'(1);
        end
    end

    // Both pulses look one edge ahead so the framer can register its outputs:
    // bit_start: a new bit begins at the next edge; bit_end: the next cycle is a bit's last.
    assign bit_start = restart || (cnt == LAST);
    assign bit_end   = !restart && (cnt == PRE_LAST);

endmodule

// File: rtl/fsk_key_framer.sv
// Serialises bytes into start/data/[parity]/stop frames on the FSK key line.
// Define FSK_FRAMER_PARITY_EN to compile in the even-parity bit.
module fsk_key_framer
    import fsk_pkg::*;
#(
    parameter int BAUD_DIV  = 1000000,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       key,
    output logic       busy,
    output logic       bit_tick,
    output logic       frame_done
);

    fsk_state_t state, state_next;
    logic       hold_valid;
    logic [7:0] hold_data;
    logic [7:0] shift;
    logic [2:0] bit_idx;
    logic       stop_idx;
    logic       key_next;
    logic       load_shift;
    logic       shift_en;
    logic       stop_adv;
    logic       restart;
    logic       last_stop;
    logic       accept;
    logic       bit_end;
    logic       bit_start;
`ifdef FSK_FRAMER_PARITY_EN
    logic       parity_acc;
`endif

    assign din_ready = !hold_valid;
    assign busy      = (state != IDLE) || hold_valid;
    assign accept    = din_valid && din_ready;
    assign restart   = (state == IDLE) && hold_valid;
    assign last_stop = int'(stop_idx) == STOP_BITS - 1;

    fsk_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .bit_end   (bit_end),
        .bit_start (bit_start)
    );

    // Outside IDLE, bit_start marks the last cycle of the current bit.
    always_comb begin
        state_next = state;
        key_next   = key;
        load_shift = 1'b0;
        shift_en   = 1'b0;
        stop_adv   = 1'b0;
        case (state)
            IDLE: begin
                key_next = FSK_IDLE_LEVEL;
                if (hold_valid) begin
                    state_next = START;
                    load_shift = 1'b1;
                    key_next   = 1'b0;
                end
            end
            START: if (bit_start) begin
                state_next = DATA;
                key_next   = shift[0];
            end
            DATA: if (bit_start) begin
                if (bit_idx == 3'(FSK_DATA_BITS - 1)) begin
`ifdef FSK_FRAMER_PARITY_EN
                    state_next = PARITY;
                    key_next   = parity_acc ^ shift[0];
`else
                    state_next = STOP;
                    key_next   = FSK_IDLE_LEVEL;
`endif
                end else begin
                    shift_en = 1'b1;
                    key_next = shift[1];
                end
            end
`ifdef FSK_FRAMER_PARITY_EN
            PARITY: if (bit_start) begin
                state_next = STOP;
                key_next   = FSK_IDLE_LEVEL;
            end
`endif
            STOP: if (bit_start) begin
                if (!last_stop) begin
                    stop_adv = 1'b1;
                end else if (hold_valid) begin
                    state_next = START;
                    load_shift = 1'b1;
                    key_next   = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            key        <= FSK_IDLE_LEVEL;
            hold_valid <= 1'b0;
            bit_tick   <= 1'b0;
            frame_done <= 1'b0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
        end else begin
            state      <= state_next;
            key        <= key_next;
            bit_tick   <= bit_start && (state_next != IDLE);
            frame_done <= bit_end && (state == STOP) && last_stop;
            if (accept) begin
                hold_valid <= 1'b1;
            end else if (load_shift) begin
                hold_valid <= 1'b0;
            end
            if (load_shift) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
            end else begin
                if (shift_en) bit_idx  <= bit_idx + 3'd1;
                if (stop_adv) stop_idx <= 1'b1;
            end
        end
    end

`ifdef FSK_FRAMER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst || load_shift) begin
            parity_acc <= 1'b0;
        end else if (state == DATA && bit_start) begin
            parity_acc <= parity_acc ^ shift[0];
        end
    end
`endif

    // NOTE: byte registers carry no reset; they are only observed while hold_valid or the FSM qualifies them.
    always_ff @(posedge clk) begin
        if (accept) hold_data <= din;
        if (load_shift) begin
            shift <= hold_data;
        end else if (shift_en) begin
            shift <= shift >> 1;
        end
    end

endmodule

// File: tb/tb_fsk_key_framer.sv
// Directed bench for fsk_key_framer: frames are compared cycle-by-cycle against
// vectors built from the byte, divider and stop count.
module tb_fsk_key_framer;

`ifdef FSK_FRAMER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din, din2;
    logic       din_valid, din_valid2;
    logic       din_ready, din_ready2;
    logic       key, key2;
    logic       busy, busy2;
    logic       bit_tick, bit_tick2;
    logic       frame_done, frame_done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fsk_key_framer #(.BAUD_DIV(4), .STOP_BITS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .key        (key),
        .busy       (busy),
        .bit_tick   (bit_tick),
        .frame_done (frame_done)
    );

    fsk_key_framer #(.BAUD_DIV(2), .STOP_BITS(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .din        (din2),
        .din_valid  (din_valid2),
        .din_ready  (din_ready2),
        .key        (key2),
        .busy       (busy2),
        .bit_tick   (bit_tick2),
        .frame_done (frame_done2)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void build_frame(input logic [7:0] b, input int div, input int stops,
                                        output logic [127:0] k, output logic [127:0] t,
                                        output logic [127:0] d, output int len);
        logic [15:0] seq;
        int nb;
        seq = '0;
        nb  = 0;
        seq[nb] = 1'b0;
        nb++;
        for (int j = 0; j < 8; j++) begin
            seq[nb] = b[j];
            nb++;
        end
        if (PAR_EN) begin
            seq[nb] = ^b;
            nb++;
        end
        for (int s = 0; s < stops; s++) begin
            seq[nb] = 1'b1;
            nb++;
        end
        len = nb * div;
        k = '0;
        t = '0;
        d = '0;
        for (int i = 0; i < len; i++) begin
            k[i] = seq[i / div];
            t[i] = (i % div) == 0;
        end
        d[len-1] = 1'b1;
    endfunction

    // Offers a byte at a negedge and holds it until accepted (bounded wait).
    task automatic send(input logic [7:0] b);
        int w;
        @(negedge clk);
        din       = b;
        din_valid = 1'b1;
        w = 0;
        while (!din_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("send_ready", din_ready, 1'b1);
        @(posedge clk);
        #1 din_valid = 1'b0;
    endtask

    task automatic cap(input int n, output logic [127:0] k, output logic [127:0] t,
                       output logic [127:0] d, output logic [127:0] bz);
        k = '0;
        t = '0;
        d = '0;
        bz = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            k[i]  = key;
            t[i]  = bit_tick;
            d[i]  = frame_done;
            bz[i] = busy;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [127:0] ek, et, ed, ek2, et2, ed2, k, t, d, bz, r, er;
        int len, len2, cnt_a, cnt_b;

        rst = 1'b1;
        din = '0;
        din_valid = 1'b0;
        din2 = '0;
        din_valid2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values, then a quiet idle line
        @(negedge clk);
        check("rst_key", key, 1'b1);
        check("rst_ready", din_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_tick", bit_tick, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_key2", key2, 1'b1);
        check("rst_ready2", din_ready2, 1'b1);
        cnt_a = 0;
        cnt_b = 0;
        repeat (100) begin
            @(negedge clk);
            if (bit_tick) cnt_a++;
            if (!key || busy) cnt_b++;
        end
        check("idle_ticks", cnt_a, 0);
        check("idle_key_busy", cnt_b, 0);

        // Single byte 0xA5: latency, bit timing and frame_done position
        send(8'hA5);
        @(negedge clk);
        check("hs_busy", busy, 1'b1);
        check("hs_ready", din_ready, 1'b0);
        check("hs_key", key, 1'b1);
        check("hs_tick", bit_tick, 1'b0);
        build_frame(8'hA5, 4, 1, ek, et, ed, len);
        cap(len, k, t, d, bz);
        check("a5_key", k, ek);
        check("a5_tick", t, et);
        check("a5_done", d, ed);
        check("a5_busy", bz, (128'(1) << len) - 128'(1));
        @(negedge clk);
        check("a5_after_key", key, 1'b1);
        check("a5_after_busy", busy, 1'b0);
        check("a5_after_done", frame_done, 1'b0);

        // 0x07: parity bit is 1 when compiled in
        send(8'h07);
        @(posedge clk);
        build_frame(8'h07, 4, 1, ek, et, ed, len);
        cap(len, k, t, d, bz);
        check("p07_key", k, ek);
        check("p07_done", d, ed);

        // Back-to-back 0x55 / 0x0F, third byte 0x33 stalled through frame 1
        send(8'h55);
        @(posedge clk);
        build_frame(8'h55, 4, 1, ek, et, ed, len);
        build_frame(8'h0F, 4, 1, ek2, et2, ed2, len2);
        ek = ek | (ek2 << len);
        et = et | (et2 << len);
        ed = ed | (ed2 << len);
        k = '0;
        t = '0;
        d = '0;
        r = '0;
        er = '0;
        for (int i = 0; i < 2 * len; i++) begin
            @(negedge clk);
            k[i] = key;
            t[i] = bit_tick;
            d[i] = frame_done;
            r[i] = din_ready;
            er[i] = (i <= 8) || (i >= len);
            if (i == 8) begin
                din = 8'h0F;
                din_valid = 1'b1;
            end else if (i == 9) begin
                din = 8'h33;
            end else if (i == len - 1) begin
                din_valid = 1'b0;
            end
        end
        check("b2b_key", k, ek);
        check("b2b_tick", t, et);
        check("b2b_done", d, ed);
        check("b2b_ready", r, er);
        @(negedge clk);
        check("b2b_after_key", key, 1'b1);
        check("b2b_after_busy", busy, 1'b0);

        // Reset during data bit 3 of 0xFF with 0x3C held
        send(8'hFF);
        @(posedge clk);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 2) begin
                din = 8'h3C;
                din_valid = 1'b1;
            end else if (i == 3) begin
                din_valid = 1'b0;
            end
        end
        check("mid_key", key, 1'b1);
        check("mid_ready", din_ready, 1'b0);
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_key", key, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", din_ready, 1'b1);
        check("abort_tick", bit_tick, 1'b0);
        cnt_a = 0;
        repeat (50) begin
            @(negedge clk);
            if (!key || busy || bit_tick) cnt_a++;
        end
        check("abort_quiet", cnt_a, 0);
        send(8'h81);
        @(posedge clk);
        build_frame(8'h81, 4, 1, ek, et, ed, len);
        cap(len, k, t, d, bz);
        check("clean_key", k, ek);
        check("clean_tick", t, et);
        check("clean_done", d, ed);

        // Two stop bits at BAUD_DIV=2
        @(negedge clk);
        din2 = 8'h00;
        din_valid2 = 1'b1;
        check("s2_ready", din_ready2, 1'b1);
        @(posedge clk);
        #1 din_valid2 = 1'b0;
        @(posedge clk);
        build_frame(8'h00, 2, 2, ek, et, ed, len);
        k = '0;
        t = '0;
        d = '0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            k[i] = key2;
            t[i] = bit_tick2;
            d[i] = frame_done2;
        end
        check("s2_key", k, ek);
        check("s2_tick", t, et);
        check("s2_done", d, ed);
        @(negedge clk);
        check("s2_after_key", key2, 1'b1);
        check("s2_after_busy", busy2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
